alu_mul: RTL and testbench

Multi-cycle integer multiplier for the ALU's MUL operation. It accepts two 32-bit operands on a start pulse and computes the product with an iterative shift-add datapath. It returns the low 32 bits as `Result`, together with a 4-bit NZCV condition code `Flag` and a one-cycle completion strobe `S`. It sits beside the ALU's adder/logic units and shares the same flag convention.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_mul_if.sv | 30 +++
 rtl/mul_flag_gen.sv | 34 +++
 rtl/alu_mul.sv | 127 ++++++++++++
 tb/tb_alu_mul.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU constants: flag bit indices, multiplier FSM
//                states and iteration count.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int FLAG_N   = 3;
  localparam int FLAG_Z   = 2;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 0;

  localparam int MUL_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_if
//  Description : Request/response bundle between the ALU and the multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_mul_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] Result;
  logic [3:0]       Flag;
  logic             S;
  logic             busy;

  modport master (
    output start, in1, in2,
    input  Result, Flag, S, busy
  );

  modport slave (
    input  start, in1, in2,
    output Result, Flag, S, busy
  );

endinterface : alu_mul_if
`default_nettype wire

// File: rtl/mul_flag_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mul_flag_gen
//  Description : Truncates a full-width product to the result and derives
//                the NZCV flags for signed or unsigned interpretation.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic [2*WIDTH-1:0] p,
  input  wire logic               signed_mode,
  output logic      [WIDTH-1:0]   result,
  output logic      [3:0]         flag
);

  logic overflow;

  always_comb begin
    result         = p[WIDTH-1:0];
    flag           = 4'b0000;
    // Signed overflow: the upper half is not a pure sign extension of the result.
    overflow       = signed_mode ? (p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}})
                                 : (p[2*WIDTH-1:WIDTH] != '0);
    flag[FLAG_N]   = p[WIDTH-1];
    flag[FLAG_Z]   = (p[WIDTH-1:0] == '0);
    flag[FLAG_C]   = overflow;
    flag[FLAG_V]   = signed_mode & overflow;
  end

endmodule : mul_flag_gen
`default_nettype wire

// File: rtl/alu_mul.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul
//  Description : Iterative shift-add multiplier, 33-cycle latency, low-half
//                result with NZCV flags. Macro MUL_SIGNED_EN selects
//                two's-complement operands (default: unsigned).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  alu_mul_if.slave  bus
);

`ifdef MUL_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  localparam int CNT_W = $clog2(MUL_ITER);

  mul_state_e             state_q,  state_d;
  logic [WIDTH-1:0]       mcand_q,  mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [2*WIDTH-1:0]     acc_q,    acc_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;
  logic                   neg_q,    neg_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic [3:0]             flag_q,   flag_d;
  logic                   s_q,      s_d;

  logic [WIDTH:0]         sum;
  logic [2*WIDTH-1:0]     product;
  logic [WIDTH-1:0]       gen_result;
  logic [3:0]             gen_flag;

  // Product with sign correction applied; only consumed in DONE.
  assign product = neg_q ? (-acc_q) : acc_q;

  mul_flag_gen #(
    .WIDTH       (WIDTH)
  ) u_flag_gen (
    .p           (product),
    .signed_mode (SIGNED_MODE),
    .result      (gen_result),
    .flag        (gen_flag)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    flag_d   = flag_q;
    s_d      = 1'b0;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = (SIGNED_MODE && bus.in1[WIDTH-1]) ? -bus.in1 : bus.in1;
          mplier_d = (SIGNED_MODE && bus.in2[WIDTH-1]) ? -bus.in2 : bus.in2;
          neg_d    = SIGNED_MODE && (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Carry out of the add lands in the top bit after the right shift.
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MUL_ITER - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        result_d = gen_result;
        flag_d   = gen_flag;
        s_d      = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      flag_q   <= 4'b0000;
      s_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      s_q      <= s_d;
    end
  end

  assign bus.Result = result_q;
  assign bus.Flag   = flag_q;
  assign bus.S      = s_q;
  assign bus.busy   = (state_q != IDLE);

endmodule : alu_mul
`default_nettype wire

// File: tb/tb_alu_mul.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mul
//  Description : Directed self-checking bench for alu_mul (both builds,
//                selected by MUL_SIGNED_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  alu_mul_if #(.WIDTH(32)) bus ();

  alu_mul #(
    .WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one operation and check the full timing window around completion.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic [3:0] exp_f);
    @(negedge clk);
    bus.in1   = a;
    bus.in2   = b;
    bus.start = 1'b1;
    @(negedge clk);              // E0 has passed
    bus.start = 1'b0;
    bus.in1   = 32'hDEAD_BEEF;   // operand changes while busy must not matter
    bus.in2   = 32'h1234_5678;
    repeat (32) @(negedge clk);  // after E32
    check({tag, "_s_before"},    32'(bus.S),    32'd0);
    check({tag, "_busy_run"},    32'(bus.busy), 32'd1);
    @(negedge clk);              // after E33
    check({tag, "_s_done"},      32'(bus.S),    32'd1);
    check({tag, "_result"},      bus.Result,    exp_r);
    check({tag, "_flag"},        32'(bus.Flag), 32'(exp_f));
    check({tag, "_busy_done"},   32'(bus.busy), 32'd0);
    @(negedge clk);              // after E34
    check({tag, "_s_fall"},      32'(bus.S),    32'd0);
    check({tag, "_result_hold"}, bus.Result,    exp_r);
  endtask

  initial begin
    int s_cnt;
    int busy_ok;

    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_result", bus.Result,    32'd0);
    check("rst_flag",   32'(bus.Flag), 32'd0);
    check("rst_s",      32'(bus.S),    32'd0);
    check("rst_busy",   32'(bus.busy), 32'd0);

    run_mul("m2x3",   32'd2,  32'd3,     32'd6,   4'b0000);
    run_mul("m1x3",   32'd1,  32'd3,     32'd3,   4'b0000);
    run_mul("m6x2",   32'd6,  32'd2,     32'd12,  4'b0000);
    run_mul("m5x9",   32'd5,  32'd9,     32'd45,  4'b0000);
    run_mul("m10x10", 32'd10, 32'd10,    32'd100, 4'b0000);
    run_mul("m10x6",  32'd10, 32'd6,     32'd60,  4'b0000);
    run_mul("zero",   32'd0,  32'd12345, 32'd0,   4'b0100);
`ifdef MUL_SIGNED_EN
    run_mul("ovf",    32'h0001_0000, 32'h0001_0000, 32'd0,         4'b0111);
    run_mul("neg",    32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, 4'b1000);
    run_mul("negneg", 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd14,        4'b0000);
`else
    run_mul("ovf",    32'h0001_0000, 32'h0001_0000, 32'd0,         4'b0110);
    run_mul("big",    32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, 4'b1010);
`endif

    // A second start while busy must be ignored.
    s_cnt   = 0;
    busy_ok = 1;
    @(negedge clk);
    bus.in1   = 32'd2;
    bus.in2   = 32'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_ok = 0;
      if (bus.S === 1'b1) s_cnt++;
      if (k == 9) begin
        bus.in1   = 32'd7;
        bus.in2   = 32'd7;
        bus.start = 1'b1;
      end
      if (k == 10) bus.start = 1'b0;
    end
    @(negedge clk);
    if (bus.S === 1'b1) s_cnt++;
    check("ign_result", bus.Result, 32'd6);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.S === 1'b1) s_cnt++;
    end
    check("ign_busy", 32'(busy_ok), 32'd1);
    check("ign_s_cnt", 32'(s_cnt), 32'd1);

    // Reset mid-operation aborts without a strobe.
    @(negedge clk);
    bus.in1   = 32'd5;
    bus.in2   = 32'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_result", bus.Result,    32'd0);
    check("abort_flag",   32'(bus.Flag), 32'd0);
    check("abort_busy",   32'(bus.busy), 32'd0);
    s_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.S === 1'b1) s_cnt++;
    end
    check("abort_no_s", 32'(s_cnt), 32'd0);
    run_mul("after_abort", 32'd5, 32'd9, 32'd45, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_alu_mul
`default_nettype wire
